deserializador_rx: RTL

- Receive-side counterpart of the TX serializer.
- Samples the 1-bit serial line at clk_32f, finds byte alignment on the comma byte (0xBC), and locks after BC_LOCK consecutive aligned commas.
- Once locked, emits parallel bytes with a valid level, a one-cycle byte strobe, and an idle flag.
- Sits at the head of phy_rx, feeding the demux/lane-distribution logic.

---
 rtl/deserializador_rx_pkg.sv | 21 ++
 rtl/deserializador_rx_comma_align.sv | 42 ++++
 rtl/deserializador_rx.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/deserializador_rx_pkg.sv
// Shared PHY definitions for the RX deserializer: comma byte, FSM state encodings,
// lock/idle defaults and a small saturating-increment helper.
package deserializador_rx_pkg;

  // Idle/alignment byte; the TX serializer sends the same constant when valid_in=0.
  localparam logic [7:0] COMMA = 8'hBC;

  // FSM state encodings
  localparam logic [1:0] SEARCH = 2'd0;
  localparam logic [1:0] SYNC   = 2'd1;
  localparam logic [1:0] ACTIVE = 2'd2;

  localparam int unsigned BC_LOCK_DEF  = 4;
  localparam int unsigned IDLE_THR_DEF = 4;

  // 4-bit increment that sticks at 15
  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/deserializador_rx_comma_align.sv
// Bit-level front end of the deserializer: serial shift register, sliding comma
// comparator, bit counter and byte-boundary indication.
module deserializador_rx_comma_align
  import deserializador_rx_pkg::*;
(
  input  logic       clk_32f,
  input  logic       reset_L,
  input  logic       data_in,
  input  logic       realign,     // restart byte framing after this edge
  output logic [7:0] nsr,         // shift register value after this edge
  output logic       comma_match,
  output logic       boundary     // this edge samples the LSB of an aligned byte
);

  // Only the low 7 bits are kept: the oldest bit falls off when forming nsr.
  logic [6:0] sr_q;
  logic [2:0] bit_cnt_q, bit_cnt_d;

  // Sliding window and comparator
  always_comb begin
    nsr         = {sr_q, data_in};
    comma_match = (nsr == COMMA);
    boundary    = (bit_cnt_q == 3'd7);
  end

  // On realign the next sampled bit is the MSB of the following byte
  always_comb begin
    bit_cnt_d = realign ? 3'd0 : bit_cnt_q + 3'd1;
  end

  // Shift register and bit counter state
  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      sr_q      <= '0;
      bit_cnt_q <= '0;
    end else begin
      sr_q      <= nsr[6:0];
      bit_cnt_q <= bit_cnt_d;
    end
  end

endmodule

// File: rtl/deserializador_rx.sv
// Serial-to-parallel receiver: comma alignment, lock FSM and parallel byte outputs.
// Optional feature macro DESER_BYTE_CNT_EN adds a saturating 16-bit data-byte counter.
module deserializador_rx
  import deserializador_rx_pkg::*;
#(
  parameter int unsigned BC_LOCK  = BC_LOCK_DEF,
  parameter int unsigned IDLE_THR = IDLE_THR_DEF
) (
  input  logic        clk_32f,
  input  logic        reset_L,
  input  logic        data_in,
  output logic [7:0]  data_out,
  output logic        valid_out,
  output logic        byte_stb,
  output logic        active,
`ifdef DESER_BYTE_CNT_EN
  output logic [15:0] byte_count,
`endif
  output logic        idle
);

  localparam logic [3:0] BC_LOCK_V  = 4'(BC_LOCK);
  localparam logic [3:0] IDLE_THR_V = 4'(IDLE_THR);

  logic [7:0] nsr;
  logic       comma_match, boundary, realign;

  logic [1:0] state_q, state_d;
  logic [3:0] bc_cnt_q, bc_cnt_d;
  logic [3:0] idle_cnt_q, idle_cnt_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       stb_q, stb_d;
  logic       idle_q, idle_d;
`ifdef DESER_BYTE_CNT_EN
  logic [15:0] cnt_q, cnt_d;
`endif

  deserializador_rx_comma_align u_align (
    .clk_32f     (clk_32f),
    .reset_L     (reset_L),
    .data_in     (data_in),
    .realign     (realign),
    .nsr         (nsr),
    .comma_match (comma_match),
    .boundary    (boundary)
  );

  // Lock FSM and next values of the byte outputs
  always_comb begin
    state_d    = state_q;
    bc_cnt_d   = bc_cnt_q;
    idle_cnt_d = idle_cnt_q;
    data_d     = data_q;
    valid_d    = valid_q;
    stb_d      = 1'b0;
    realign    = 1'b0;
`ifdef DESER_BYTE_CNT_EN
    cnt_d      = cnt_q;
`endif
    case (state_q)
      SEARCH: begin
        if (comma_match) begin
          realign  = 1'b1;
          bc_cnt_d = 4'd1;
          if (BC_LOCK_V == 4'd1) begin
            state_d    = ACTIVE;
            idle_cnt_d = '0;
          end else begin
            state_d = SYNC;
          end
        end
      end
      SYNC: begin
        if (boundary) begin
          stb_d = 1'b1;
          if (comma_match) begin
            bc_cnt_d = bc_cnt_q + 4'd1;
            if (bc_cnt_q + 4'd1 == BC_LOCK_V) begin
              state_d    = ACTIVE;
              idle_cnt_d = '0;
            end
          end else begin
            state_d  = SEARCH;
            bc_cnt_d = '0;
          end
        end
      end
      ACTIVE: begin
        if (boundary) begin
          stb_d = 1'b1;
          if (!comma_match) begin
            data_d     = nsr;
            valid_d    = 1'b1;
            idle_cnt_d = '0;
`ifdef DESER_BYTE_CNT_EN
            cnt_d      = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
`endif
          end else begin
            valid_d    = 1'b0;
            idle_cnt_d = sat_inc4(idle_cnt_q);
          end
        end
      end
      default: state_d = SEARCH;
    endcase
    idle_d = (state_d != ACTIVE) || (idle_cnt_d >= IDLE_THR_V);
  end

  // State and output registers
  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      state_q    <= SEARCH;
      bc_cnt_q   <= '0;
      idle_cnt_q <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      stb_q      <= 1'b0;
      idle_q     <= 1'b1;
`ifdef DESER_BYTE_CNT_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      bc_cnt_q   <= bc_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      stb_q      <= stb_d;
      idle_q     <= idle_d;
`ifdef DESER_BYTE_CNT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  // Output drive
  always_comb begin
    data_out  = data_q;
    valid_out = valid_q;
    byte_stb  = stb_q;
    active    = (state_q == ACTIVE);
    idle      = idle_q;
`ifdef DESER_BYTE_CNT_EN
    byte_count = cnt_q;
`endif
  end

endmodule
